// File: rtl/dac_waveform_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dac_waveform_sequencer_pkg
// Description : Shared definitions for the DAC waveform sequencer and the
//               DAC output stage (state encoding, idle word, main-state slots).
// Revision    : 1.0 - initial release
// ============================================================================
package dac_waveform_sequencer_pkg;

    // Sequencer playback states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Offset-binary midrange: 0 V at the DAC output
    localparam logic [15:0] C_IDLE_WORD = 16'h8000;

    // Main sequencer state on which one sample frame is taken
    localparam logic [31:0] C_MS_ADVANCE = 32'd99;

endpackage
`default_nettype wire

// File: rtl/dac_waveform_sequencer_ram.sv
`default_nettype none
// ============================================================================
// Module      : seq_waveform_ram
// Description : Simple dual-port synchronous RAM, read-first, one-cycle read
//               latency. Host writes on port A, sequencer reads on port B.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_waveform_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;

    // Write and read in one block so a same-address collision returns old data
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/dac_waveform_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dac_waveform_sequencer
// Description : Stored-waveform playback for one analog channel. Emits one
//               16-bit offset-binary word per sample frame to the DAC stage,
//               with software arming, optional TTL trigger and pass counting.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_waveform_sequencer
    import dac_waveform_sequencer_pkg::*;
#(
    parameter logic [31:0] MS_ADVANCE = C_MS_ADVANCE,
    parameter int          ADDR_W     = 10,
    parameter logic [15:0] IDLE_WORD  = C_IDLE_WORD
) (
    input  logic              dataclk,
    input  logic              reset,
    input  logic [31:0]       main_state,
    input  logic [5:0]        channel,
    input  logic              seq_en,
    input  logic              trigger_en,
    input  logic              trigger_in,
    input  logic              trigger_pol,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] stop_addr,
    input  logic [15:0]       n_repeats,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    output logic [15:0]       DAC_sequencer_in,
    output logic              use_sequencer,
    output logic              seq_running,
    output logic              seq_done,
    output logic [ADDR_W-1:0] seq_addr
);

    seq_state_t        r_state;
    seq_state_t        w_state_next;
    logic [1:0]        r_trig_sync;
    logic              r_trig_sync_d;
    logic              r_trig;
    logic              w_edge;
    logic [ADDR_W-1:0] r_ptr;
    logic [15:0]       r_pass_cnt;
    logic [15:0]       w_pass_next;
    logic [15:0]       r_dac;
    logic              r_use;
    logic [15:0]       w_ram_q;
    logic              w_frame;
    logic              w_adv;
    logic              w_at_stop;
    logic              w_last;

    assign w_frame     = (main_state == MS_ADVANCE) && (channel == 6'd0);
    assign w_adv       = (r_state == ST_RUN) && w_frame && seq_en;
    assign w_at_stop   = (r_ptr == stop_addr);
    assign w_pass_next = r_pass_cnt + 16'd1;
    assign w_last      = w_adv && w_at_stop && (n_repeats != 16'd0) && (w_pass_next == n_repeats);
    assign w_edge      = trigger_pol ? (~r_trig_sync[1] & r_trig_sync_d)
                                     : (r_trig_sync[1] & ~r_trig_sync_d);

    seq_waveform_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (16)
    ) u_ram (
        .clk       (dataclk),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (r_ptr),
        .o_rd_data (w_ram_q)
    );

    // Trigger synchroniser plus registered edge pulse (pin to pulse: 3 cycles)
    always_ff @(posedge dataclk) begin
        if (reset) begin
            r_trig_sync   <= 2'b00;
            r_trig_sync_d <= 1'b0;
            r_trig        <= 1'b0;
        end else begin
            r_trig_sync   <= {r_trig_sync[0], trigger_in};
            r_trig_sync_d <= r_trig_sync[1];
            r_trig        <= w_edge;
        end
    end

    // State register
    always_ff @(posedge dataclk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; dropping seq_en aborts from any state
    always_comb begin
        w_state_next = r_state;
        if (!seq_en) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_next = trigger_en ? ST_ARMED : ST_RUN;
                ST_ARMED: if (r_trig) w_state_next = ST_RUN;
                ST_RUN:   if (w_last) w_state_next = ST_DONE;
                ST_DONE:  w_state_next = ST_DONE;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // Pointer, pass counter and registered output word
    always_ff @(posedge dataclk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_pass_cnt <= 16'd0;
            r_dac      <= IDLE_WORD;
            r_use      <= 1'b0;
        end else begin
            if (w_adv) begin
                r_dac <= w_ram_q;
                r_use <= 1'b1;
                if (w_at_stop) begin
                    r_ptr      <= start_addr;
                    r_pass_cnt <= w_pass_next;
                end else begin
                    r_ptr <= r_ptr + 1'b1;
                end
            end
            // Before RUN the pointer tracks the live start address so ram_q
            // already holds the first word when playback begins.
            if ((r_state == ST_IDLE) || (r_state == ST_ARMED)) begin
                r_ptr      <= start_addr;
                r_pass_cnt <= 16'd0;
            end
            if (!seq_en || (r_state == ST_IDLE)) begin
                r_dac <= IDLE_WORD;
            end
            if (r_state == ST_IDLE) begin
                r_use <= 1'b0;
            end
        end
    end

    assign DAC_sequencer_in = r_dac;
    assign use_sequencer    = r_use;
    assign seq_running      = (r_state == ST_RUN);
    assign seq_done         = (r_state == ST_DONE);
    assign seq_addr         = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_dac_waveform_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_waveform_sequencer
// Description : Self-checking bench for dac_waveform_sequencer. Frames occur
//               every 8 cycles; a decoy slot (advance state, channel 1) sits
//               between frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_waveform_sequencer;

    localparam int          AW = 4;
    localparam logic [31:0] MS = 32'd99;

    logic          dataclk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   main_state = 32'd0;
    logic [5:0]    channel = 6'd0;
    logic          seq_en = 1'b0;
    logic          trigger_en = 1'b0;
    logic          trigger_in = 1'b0;
    logic          trigger_pol = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] stop_addr = '0;
    logic [15:0]   n_repeats = 16'd0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [15:0]   wr_data = 16'd0;
    logic [15:0]   DAC_sequencer_in;
    logic          use_sequencer;
    logic          seq_running;
    logic          seq_done;
    logic [AW-1:0] seq_addr;

    int            checks = 0;
    int            errors = 0;
    logic [15:0]   mem_model [16];
    logic [15:0]   exp_q [$];
    int unsigned   phase = 0;
    logic          frame_now;

    dac_waveform_sequencer #(
        .MS_ADVANCE (MS),
        .ADDR_W     (AW),
        .IDLE_WORD  (16'h8000)
    ) dut (
        .dataclk          (dataclk),
        .reset            (reset),
        .main_state       (main_state),
        .channel          (channel),
        .seq_en           (seq_en),
        .trigger_en       (trigger_en),
        .trigger_in       (trigger_in),
        .trigger_pol      (trigger_pol),
        .start_addr       (start_addr),
        .stop_addr        (stop_addr),
        .n_repeats        (n_repeats),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .DAC_sequencer_in (DAC_sequencer_in),
        .use_sequencer    (use_sequencer),
        .seq_running      (seq_running),
        .seq_done         (seq_done),
        .seq_addr         (seq_addr)
    );

    always #5 dataclk = ~dataclk;

    // Main sequencer model: frame in phase 3, decoy (channel 1) in phase 6
    always @(posedge dataclk) begin
        #1;
        phase      = (phase + 1) % 8;
        main_state = (phase == 3 || phase == 6) ? MS : 32'(phase);
        channel    = (phase == 6) ? 6'd1 : 6'd0;
    end

    assign frame_now = (main_state == MS) && (channel == 6'd0);

    // Advance to the next frame edge, then to the following negedge
    task automatic next_frame();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge dataclk);
            if (frame_now) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout got=0 want=1");
        end
        @(negedge dataclk);
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [15:0] d);
        @(negedge dataclk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge dataclk);
        wr_en = 1'b0;
        mem_model[a] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge dataclk);
        checks++; if (DAC_sequencer_in !== 16'h8000) begin errors++; $display("FAIL reset_dac got=%h want=8000", DAC_sequencer_in); end
        checks++; if (use_sequencer !== 1'b0) begin errors++; $display("FAIL reset_use got=%b want=0", use_sequencer); end
        checks++; if (seq_running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b want=0", seq_running); end
        checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", seq_done); end
        checks++; if (seq_addr !== 4'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", seq_addr); end
        reset = 1'b0;
        @(negedge dataclk);
    endtask

    task automatic test_basic();
        logic [15:0] exp;
        for (int i = 0; i < 4; i++) host_write(4'(i), 16'(1000 * (i + 1)));
        start_addr = 4'd0; stop_addr = 4'd3; n_repeats = 16'd2; trigger_en = 1'b0;
        for (int p = 0; p < 2; p++) for (int i = 0; i < 4; i++) exp_q.push_back(mem_model[i]);
        @(negedge dataclk); seq_en = 1'b1;
        @(posedge dataclk);
        while (exp_q.size() > 0) begin
            next_frame();
            exp = exp_q.pop_front();
            checks++; if (DAC_sequencer_in !== exp) begin errors++; $display("FAIL basic_word got=%0d want=%0d", DAC_sequencer_in, exp); end
            checks++; if (use_sequencer !== 1'b1) begin errors++; $display("FAIL basic_use got=%b want=1", use_sequencer); end
        end
        checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL basic_done got=%b want=1", seq_done); end
        next_frame(); next_frame();
        checks++; if (DAC_sequencer_in !== 16'd4000) begin errors++; $display("FAIL basic_hold got=%0d want=4000", DAC_sequencer_in); end
        checks++; if (seq_done !== 1'b1 || use_sequencer !== 1'b1) begin errors++; $display("FAIL basic_hold_flags got=%b%b want=11", seq_done, use_sequencer); end
        seq_en = 1'b0;
        repeat (2) @(negedge dataclk);
    endtask

    // Rising-edge trigger timed so RUN entry coincides with a frame
    task automatic test_trigger();
        logic [15:0] exp;
        for (int i = 8; i < 11; i++) host_write(4'(i), 16'(16'h1100 + i));
        start_addr = 4'd8; stop_addr = 4'd10; n_repeats = 16'd1;
        trigger_en = 1'b1; trigger_pol = 1'b0; trigger_in = 1'b0;
        @(negedge dataclk); seq_en = 1'b1;
        for (int f = 0; f < 5; f++) begin
            next_frame();
            checks++; if (DAC_sequencer_in !== 16'h8000 || use_sequencer !== 1'b0) begin errors++; $display("FAIL armed_idle got=%h/%b want=8000/0", DAC_sequencer_in, use_sequencer); end
        end
        repeat (4) @(posedge dataclk);
        #1 trigger_in = 1'b1;
        repeat (3) @(posedge dataclk);
        @(negedge dataclk);
        checks++; if (seq_running !== 1'b0) begin errors++; $display("FAIL trig_early got=%b want=0", seq_running); end
        @(posedge dataclk);
        @(negedge dataclk);
        checks++; if (seq_running !== 1'b1) begin errors++; $display("FAIL trig_latency got=%b want=1", seq_running); end
        checks++; if (DAC_sequencer_in !== 16'h8000 || use_sequencer !== 1'b0) begin errors++; $display("FAIL trig_frame_consumed got=%h/%b want=8000/0", DAC_sequencer_in, use_sequencer); end
        for (int i = 8; i < 11; i++) exp_q.push_back(mem_model[i]);
        while (exp_q.size() > 0) begin
            next_frame();
            exp = exp_q.pop_front();
            checks++; if (DAC_sequencer_in !== exp) begin errors++; $display("FAIL trig_word got=%h want=%h", DAC_sequencer_in, exp); end
        end
        checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL trig_done got=%b want=1", seq_done); end
        seq_en = 1'b0;
        repeat (2) @(negedge dataclk);
    endtask

    // Reversed window with a falling-edge trigger
    task automatic test_wrap();
        logic [15:0] exp;
        logic [AW-1:0] addr_q [$];
        logic [AW-1:0] ea;
        bit got = 0;
        host_write(4'd14, 16'hA00E); host_write(4'd15, 16'hA00F);
        host_write(4'd0, 16'hA000);  host_write(4'd1, 16'hA001);
        start_addr = 4'd14; stop_addr = 4'd1; n_repeats = 16'd1;
        trigger_en = 1'b1; trigger_pol = 1'b1; trigger_in = 1'b1;
        repeat (6) @(negedge dataclk);
        seq_en = 1'b1;
        next_frame(); next_frame();
        checks++; if (seq_running !== 1'b0) begin errors++; $display("FAIL wrap_armed got=%b want=0", seq_running); end
        trigger_in = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge dataclk);
            if (seq_running === 1'b1) got = 1;
        end
        checks++; if (!got) begin errors++; $display("FAIL wrap_trigger got=%b want=1", seq_running); end
        exp_q.push_back(mem_model[14]); addr_q.push_back(4'd15);
        exp_q.push_back(mem_model[15]); addr_q.push_back(4'd0);
        exp_q.push_back(mem_model[0]);  addr_q.push_back(4'd1);
        exp_q.push_back(mem_model[1]);  addr_q.push_back(4'd14);
        while (exp_q.size() > 0) begin
            next_frame();
            exp = exp_q.pop_front();
            ea  = addr_q.pop_front();
            checks++; if (DAC_sequencer_in !== exp) begin errors++; $display("FAIL wrap_word got=%h want=%h", DAC_sequencer_in, exp); end
            checks++; if (seq_addr !== ea) begin errors++; $display("FAIL wrap_addr got=%0d want=%0d", seq_addr, ea); end
        end
        checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL wrap_done got=%b want=1", seq_done); end
        seq_en = 1'b0; trigger_en = 1'b0; trigger_pol = 1'b0;
        repeat (2) @(negedge dataclk);
    endtask

    task automatic test_abort_reset();
        logic [15:0] exp;
        for (int i = 0; i < 8; i++) host_write(4'(i), 16'(i * 111 + 7));
        start_addr = 4'd0; stop_addr = 4'd7; n_repeats = 16'd0;
        @(negedge dataclk); seq_en = 1'b1;
        @(posedge dataclk);
        for (int i = 0; i < 5; i++) exp_q.push_back(mem_model[i]);
        while (exp_q.size() > 0) begin
            next_frame();
            exp = exp_q.pop_front();
            checks++; if (DAC_sequencer_in !== exp) begin errors++; $display("FAIL abort_word got=%0d want=%0d", DAC_sequencer_in, exp); end
        end
        checks++; if (seq_addr !== 4'd5) begin errors++; $display("FAIL abort_addr got=%0d want=5", seq_addr); end
        seq_en = 1'b0;
        @(negedge dataclk);
        checks++; if (seq_running !== 1'b0 || DAC_sequencer_in !== 16'h8000) begin errors++; $display("FAIL abort_idle got=%b/%h want=0/8000", seq_running, DAC_sequencer_in); end
        checks++; if (use_sequencer !== 1'b1) begin errors++; $display("FAIL abort_use_hold got=%b want=1", use_sequencer); end
        @(negedge dataclk);
        checks++; if (use_sequencer !== 1'b0) begin errors++; $display("FAIL abort_use_fall got=%b want=0", use_sequencer); end
        checks++; if (seq_addr !== 4'd0) begin errors++; $display("FAIL abort_ptr got=%0d want=0", seq_addr); end
        // Reset mid-RUN, then replay to confirm RAM survived
        seq_en = 1'b1;
        @(posedge dataclk);
        next_frame(); next_frame(); next_frame();
        reset = 1'b1; seq_en = 1'b0;
        @(negedge dataclk);
        checks++; if (DAC_sequencer_in !== 16'h8000 || use_sequencer !== 1'b0) begin errors++; $display("FAIL rst_out got=%h/%b want=8000/0", DAC_sequencer_in, use_sequencer); end
        checks++; if (seq_running !== 1'b0 || seq_done !== 1'b0 || seq_addr !== 4'd0) begin errors++; $display("FAIL rst_state got=%b%b/%0d want=00/0", seq_running, seq_done, seq_addr); end
        reset = 1'b0;
        repeat (2) @(negedge dataclk);
        seq_en = 1'b1;
        @(posedge dataclk);
        for (int i = 0; i < 9; i++) exp_q.push_back(mem_model[i % 8]);
        while (exp_q.size() > 0) begin
            next_frame();
            exp = exp_q.pop_front();
            checks++; if (DAC_sequencer_in !== exp) begin errors++; $display("FAIL replay_word got=%0d want=%0d", DAC_sequencer_in, exp); end
        end
        seq_en = 1'b0;
        repeat (2) @(negedge dataclk);
    endtask

    // Host write to the live pointer on the edge that fetches the next word
    task automatic test_collision();
        logic [15:0] exp;
        start_addr = 4'd0; stop_addr = 4'd7; n_repeats = 16'd0; trigger_en = 1'b0;
        @(negedge dataclk); seq_en = 1'b1;
        @(posedge dataclk);
        next_frame();
        checks++; if (DAC_sequencer_in !== mem_model[0]) begin errors++; $display("FAIL coll_first got=%0d want=%0d", DAC_sequencer_in, mem_model[0]); end
        repeat (6) @(posedge dataclk);
        #1 wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'hBEEF;
        @(posedge dataclk);
        #1 wr_en = 1'b0;
        exp_q.push_back(mem_model[1]);
        mem_model[1] = 16'hBEEF;
        for (int i = 2; i < 10; i++) exp_q.push_back(mem_model[i % 8]);
        while (exp_q.size() > 0) begin
            next_frame();
            exp = exp_q.pop_front();
            checks++; if (DAC_sequencer_in !== exp) begin errors++; $display("FAIL coll_word got=%h want=%h", DAC_sequencer_in, exp); end
        end
        seq_en = 1'b0;
        repeat (2) @(negedge dataclk);
    endtask

    task automatic test_infinite();
        logic [15:0] exp;
        start_addr = 4'd2; stop_addr = 4'd4; n_repeats = 16'd0; trigger_en = 1'b0;
        for (int i = 0; i < 1000; i++) exp_q.push_back(mem_model[2 + (i % 3)]);
        @(negedge dataclk); seq_en = 1'b1;
        @(posedge dataclk);
        while (exp_q.size() > 0) begin
            next_frame();
            exp = exp_q.pop_front();
            checks++; if (DAC_sequencer_in !== exp) begin errors++; $display("FAIL inf_word got=%0d want=%0d", DAC_sequencer_in, exp); end
            checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL inf_done got=%b want=0", seq_done); end
        end
        seq_en = 1'b0;
        repeat (2) @(negedge dataclk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_trigger();
        test_wrap();
        test_abort_reset();
        test_collision();
        test_infinite();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
